// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one byte-wide memory port between the core and a DMA requester,
// pacing the core through core_ce with wait states and bounded DMA bursts.
module bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_run,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        core_ce,
  input  logic        dma_req,
  input  logic [19:0] dma_address,
  input  logic        dma_we,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  input  logic [7:0]  mem_in
);
  typedef enum logic [1:0] {ARB, CPU_WAIT, DMA_WAIT} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  burst_q, burst_d;
  logic [19:0] daddr_q, daddr_d;
  logic        dwe_q, dwe_d;
  logic [7:0]  dwdata_q, dwdata_d;
  logic        ce, ack, we;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wcnt_d   = wcnt_q;
    burst_d  = burst_q;
    daddr_d  = daddr_q;
    dwe_d    = dwe_q;
    dwdata_d = dwdata_q;
    ce       = 1'b0;
    ack      = 1'b0;
    we       = 1'b0;
    case (state_q)
      ARB: begin
        if (dma_req && (burst_q < MB || !cpu_run)) begin
          daddr_d  = dma_address;
          dwe_d    = dma_we;
          dwdata_d = dma_wdata;
          owner_d  = 1'b1;
          burst_d  = (burst_q == 4'hf) ? burst_q : burst_q + 4'd1;
          wcnt_d   = WS;
          state_d  = DMA_WAIT;
        end else if (cpu_run) begin
          owner_d = 1'b0;
          burst_d = 4'd0;
          wcnt_d  = WS;
          state_d = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        wcnt_d  = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : wcnt_q;
        ce      = (wcnt_q == 4'd0);
        we      = (wcnt_q == 4'd0) && cpu_we;
        state_d = (wcnt_q == 4'd0) ? ARB : CPU_WAIT;
      end
      DMA_WAIT: begin
        wcnt_d  = (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : wcnt_q;
        ack     = (wcnt_q == 4'd0);
        we      = (wcnt_q == 4'd0) && dwe_q;
        state_d = (wcnt_q == 4'd0) ? ARB : DMA_WAIT;
      end
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      wcnt_q  <= 4'd0;
      burst_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
      burst_q <= burst_d;
    end
    daddr_q  <= daddr_d;
    dwe_q    <= dwe_d;
    dwdata_q <= dwdata_d;
  end
  // strobes are masked while reset is high so an interrupted slot never completes
  assign core_ce     = ce & ~reset;
  assign dma_ack     = ack & ~reset;
  assign mem_we      = we & ~reset;
  assign mem_address = owner_q ? daddr_q : cpu_address;
  assign mem_out     = owner_q ? dwdata_q : cpu_out;
  assign cpu_in      = mem_in;
  assign dma_rdata   = mem_in;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiters (1 and 2 wait states) checked against a slot-level model,
// a per-cycle vector table and directed corner-case sequences.
module tb_bus_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic        reset, cpu_run, cpu_we, dma_req, dma_we;
  logic [19:0] cpu_address, dma_address;
  logic [7:0]  cpu_out, dma_wdata, mem_in;
  logic [7:0]  a_cpu_in, a_rdata, a_out, b_cpu_in, b_rdata, b_out;
  logic        a_ce, a_ack, a_we, b_ce, b_ack, b_we;
  logic [19:0] a_addr, b_addr;
  bus_arbiter #(.WAIT_STATES(1), .MAX_BURST(4)) dut_a (
    .clock(clock), .reset(reset), .cpu_run(cpu_run), .cpu_address(cpu_address),
    .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_in(a_cpu_in), .core_ce(a_ce),
    .dma_req(dma_req), .dma_address(dma_address), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(a_ack), .dma_rdata(a_rdata), .mem_address(a_addr), .mem_out(a_out),
    .mem_we(a_we), .mem_in(mem_in));
  bus_arbiter #(.WAIT_STATES(2), .MAX_BURST(4)) dut_b (
    .clock(clock), .reset(reset), .cpu_run(cpu_run), .cpu_address(cpu_address),
    .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_in(b_cpu_in), .core_ce(b_ce),
    .dma_req(dma_req), .dma_address(dma_address), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(b_ack), .dma_rdata(b_rdata), .mem_address(b_addr), .mem_out(b_out),
    .mem_we(b_we), .mem_in(mem_in));
  // bit layout: [46] ce [45] ack [44] we [43:24] addr [23:16] out [15:8] cpu_in [7:0] rdata
  wire [46:0] vec_a = {a_ce, a_ack, a_we, a_addr, a_out, a_cpu_in, a_ack ? a_rdata : 8'h00};
  wire [46:0] vec_b = {b_ce, b_ack, b_we, b_addr, b_out, b_cpu_in, b_ack ? b_rdata : 8'h00};
  typedef struct {
    bit          busy;
    bit          who;
    int          left;
    logic [19:0] la;
    bit          lwe;
    logic [7:0]  ld;
    int          burst;
  } mst_t;
  mst_t ma, mb;
  int n_chk = 0, n_fail = 0;
  logic [46:0] sa, sb;
  function automatic mst_t mstep(mst_t s, int ws, int mbst);
    mst_t n = s;
    if (reset) begin
      n.busy = 0; n.who = 0; n.burst = 0; n.left = 0;
    end else if (!s.busy) begin
      if (dma_req && (s.burst < mbst || !cpu_run)) begin
        n.busy = 1; n.who = 1; n.left = ws + 1;
        n.la = dma_address; n.lwe = dma_we; n.ld = dma_wdata;
        n.burst = (s.burst < 15) ? s.burst + 1 : 15;
      end else if (cpu_run) begin
        n.busy = 1; n.who = 0; n.left = ws + 1; n.burst = 0;
      end
    end else begin
      n.left = s.left - 1;
      if (n.left == 0) n.busy = 0;
    end
    return n;
  endfunction
  function automatic logic [46:0] exp_vec(mst_t s);
    bit fin = !reset && s.busy && s.left == 1;
    bit ce  = fin && !s.who;
    bit ack = fin && s.who;
    bit we  = fin && (s.who ? s.lwe : cpu_we);
    return {ce, ack, we, s.who ? s.la : cpu_address, s.who ? s.ld : cpu_out, mem_in,
            ack ? mem_in : 8'h00};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
    chk("model_ws1", 64'(vec_a), 64'(exp_vec(ma)));
    chk("model_ws2", 64'(vec_b), 64'(exp_vec(mb)));
    sa = vec_a;
    sb = vec_b;
    @(posedge clock);
    ma = mstep(ma, 1, 4);
    mb = mstep(mb, 2, 4);
    #1;
  endtask
  task automatic drive(bit rst, bit run, bit req, bit cwe, bit dwe);
    reset = rst; cpu_run = run; dma_req = req; cpu_we = cwe; dma_we = dwe;
    cpu_address = 20'($urandom); dma_address = 20'($urandom);
    cpu_out = 8'($urandom); dma_wdata = 8'($urandom); mem_in = 8'($urandom);
  endtask
  typedef struct {
    bit rst, run, req, cwe, dwe;
    bit e_ce, e_ack, e_we;
  } vec_t;
  vec_t tbl[30];
  initial begin
    string pat;
    int guard, wes, ces;
    bit seen;
    tbl = '{
      '{1,0,0,0,0, 0,0,0}, '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 1,0,0},
      '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 1,0,0},
      '{0,1,0,1,0, 0,0,0}, '{0,1,0,1,0, 0,0,0}, '{0,1,0,1,0, 1,0,1},
      '{0,1,1,0,1, 0,0,0}, '{0,1,1,0,1, 0,0,0}, '{0,1,1,0,1, 0,1,1},
      '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 0,0,0}, '{0,1,0,0,0, 1,0,0},
      '{0,1,1,0,1, 0,0,0}, '{0,1,1,0,1, 0,0,0}, '{1,1,1,0,1, 0,0,0},
      '{0,1,1,0,1, 0,0,0}, '{0,1,1,0,1, 0,0,0}, '{0,1,1,0,1, 0,1,1},
      '{0,0,0,0,0, 0,0,0}, '{0,1,0,1,0, 0,0,0}, '{0,1,0,1,0, 0,0,0}, '{0,1,0,1,0, 1,0,1},
      '{0,1,0,0,0, 0,0,0}, '{0,0,0,0,0, 0,0,0}, '{0,0,0,0,0, 1,0,0}, '{0,0,0,0,0, 0,0,0}
    };
    ma = '{default: '0};
    mb = '{default: '0};
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].req, tbl[i].cwe, tbl[i].dwe);
      tick();
      chk($sformatf("tbl_row%0d", i), 64'({sa[46], sa[45], sa[44]}),
          64'({tbl[i].e_ce, tbl[i].e_ack, tbl[i].e_we}));
    end
    // CPU write with two wait states: strobe lands only on the core_ce cycle
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 1, 0);
    cpu_address = 20'hF0010; cpu_out = 8'h5A;
    guard = 0; wes = 0; seen = 0;
    while (!seen && guard < 10) begin
      tick();
      guard++;
      wes += int'(sb[44]);
      if (sb[46]) begin
        seen = 1;
        chk("cpu_wr_cycle", 64'(guard), 64'(4));
        chk("cpu_wr_we", 64'(sb[44]), 64'(1));
        chk("cpu_wr_addr", 64'(sb[43:24]), 64'(20'hF0010));
        chk("cpu_wr_data", 64'(sb[23:16]), 64'(8'h5A));
      end
    end
    chk("cpu_wr_seen", 64'(seen), 64'(1));
    chk("cpu_wr_we_count", 64'(wes), 64'(1));
    // DMA read with the core halted
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    dma_address = 20'hB8000; mem_in = 8'h41;
    guard = 0; ces = 0; seen = 0;
    while (!seen && guard < 10) begin
      tick();
      guard++;
      ces += int'(sb[46]);
      if (sb[45]) begin
        seen = 1;
        chk("dma_rd_data", 64'(sb[7:0]), 64'(8'h41));
        chk("dma_rd_addr", 64'(sb[43:24]), 64'(20'hB8000));
        chk("dma_rd_we", 64'(sb[44]), 64'(0));
      end
    end
    chk("dma_rd_seen", 64'(seen), 64'(1));
    dma_req = 0;
    tick();
    chk("dma_ack_pulse", 64'(sb[45]), 64'(0));
    chk("dma_rd_no_ce", 64'(ces), 64'(0));
    // simultaneous request and run from reset: DMA first, then bursts of four
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0);
    pat = "";
    guard = 0;
    while (pat.len() < 15 && guard < 200) begin
      tick();
      guard++;
      if (sa[45] && sa[46]) pat = {pat, "X"};
      else if (sa[45]) pat = {pat, "D"};
      else if (sa[46]) pat = {pat, "C"};
    end
    n_chk++;
    if (pat != "DDDDCDDDDCDDDDC") begin
      n_fail++;
      $display("FAIL fairness: got %s expected DDDDCDDDDCDDDDC", pat);
    end
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            1'($urandom), 1'($urandom));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares one 20-bit byte-wide memory port between the x86 core and one DMA-style requester, such as a video fetch unit or disk controller. The block sequences the core by generating its clock-enable `core_ce`, so one core step happens per granted memory slot. It inserts wait states for slow memory and enforces bounded DMA priority, so the core is never starved.

Parameters:
- WAIT_STATES, 1, extra cycles the address is held before the data/write cycle; legal range 0..15.
- MAX_BURST, 4, maximum consecutive DMA grants while the core is waiting; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_run  in  1  core enabled; 0 = core halted and never granted.
- cpu_address  in  20  core address; stable while core_ce=0.
- cpu_out  in  8  core write data.
- cpu_we  in  1  core write request.
- cpu_in  out  8  read data to core; equals mem_in.
- core_ce  out  1  core clock-enable; one-cycle pulse per CPU slot.
- dma_req  in  1  DMA request level; held until dma_ack.
- dma_address  in  20  DMA address.
- dma_we  in  1  DMA write.
- dma_wdata  in  8  DMA write data.
- dma_ack  out  1  one-cycle pulse marking DMA completion.
- dma_rdata  out  8  DMA read data; valid only while dma_ack=1.
- mem_address  out  20  memory address.
- mem_out  out  8  memory write data.
- mem_we  out  1  memory write strobe.
- mem_in  in  8  memory read data.

Behaviour:
- States: ARB, CPU_WAIT, DMA_WAIT. Registers: `owner` (0=CPU, 1=DMA), `wcnt` (4 bits), `burst` (4 bits), DMA latches for address/we/wdata.
- Reset (any state): state=ARB, owner=0, wcnt=0, burst=0.
  - core_ce=0, dma_ack=0, mem_we=0 held during reset and in the cycle after.
  - An interrupted slot is simply dropped: no write is issued.
- ARB takes one cycle. core_ce=0, mem_we=0, dma_ack=0.
  - Grant DMA if dma_req=1 and (burst<MAX_BURST or cpu_run=0).
    - Latch dma_address/dma_we/dma_wdata; owner<=1; burst<=burst+1 (saturating); wcnt<=WAIT_STATES; go to DMA_WAIT.
  - Else grant CPU if cpu_run=1.
    - owner<=0; burst<=0; wcnt<=WAIT_STATES; go to CPU_WAIT.
  - Else stay in ARB (idle).
  - burst is NOT cleared by idle cycles; it is cleared only by a CPU grant.
- mem_address: the DMA latch when owner=1, else cpu_address (ARB included). mem_out is muxed the same way.
- CPU_WAIT:
  - While wcnt≠0: wcnt decrements each cycle; core_ce=0; mem_we=0.
  - When wcnt=0: core_ce=1, mem_we=cpu_we, cpu_in=mem_in; next state ARB.
- DMA_WAIT:
  - Counts identically.
  - When wcnt=0: dma_ack=1, mem_we=latched dma_we, dma_rdata=mem_in; next state ARB.
- Slot lengths: CPU slot = WAIT_STATES+2 cycles; DMA slot = WAIT_STATES+2 cycles.
- mem_we is asserted for exactly one cycle per write slot, in the final cycle only.
- Memory contract:
  - Read data must be valid within WAIT_STATES+1 cycles of the address first appearing.
  - WAIT_STATES=0 is legal only for combinational-read memory.
- Request rules:
  - dma_req must remain high until ack. Dropping it early is undefined, but the arbiter still completes the latched slot.
  - If dma_req is still high in the ARB cycle after an ack, it is a new request.
- Fairness: with dma_req constantly high and cpu_run=1, grants follow the pattern MAX_BURST DMA slots, then 1 CPU slot, repeating.
- cpu_run falling mid CPU_WAIT: the slot completes (core_ce still pulses). cpu_run is sampled only in ARB.

Test Plan:
1. Reset, cpu_run=1, dma_req=0, WAIT_STATES=1 → core_ce pulses every 3rd cycle, first pulse at cycle 3 after reset release; mem_address=cpu_address; mem_we=0 unless cpu_we.
2. CPU write 0x5A to 0xF0010 with WAIT_STATES=2 → mem_we high exactly 1 cycle, coincident with core_ce, mem_out=0x5A, mem_address=0xF0010.
3. DMA read from 0xB8000 with memory returning 0x41, cpu_run=0 → dma_ack 1 cycle, dma_rdata=0x41 on that cycle, core_ce never asserted.
4. dma_req held high, cpu_run=1, MAX_BURST=4 → grant sequence DDDDC DDDDC…; burst resets on C; no core_ce during D slots.
5. reset asserted in the middle of a DMA_WAIT write → no mem_we, no dma_ack; after release, first grant follows ARB rules with burst=0.
6. dma_req and cpu_run rise in the same cycle, burst=0 → DMA granted first; CPU granted in the next ARB cycle only if dma_req is low or burst=MAX_BURST.
